// File: rtl/contador_duzias_embalagem.sv
// rtl/contador_duzias_embalagem.sv - approved-bottle dozen counter with timed packaging actuator
// Counts bottle rising edges into dozens, pulses the packer per dozen and flags line capacity.
module contador_duzias_embalagem #(
   parameter int GARRAFAS_POR_DUZIA = 12,
   parameter int MAX_DUZIAS         = 10,
   parameter int TEMPO_EMBALAGEM    = 25000000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       garrafa_aprovada,
   input  logic       limpar_contagem,
   output logic [3:0] contagem_garrafas,
   output logic [6:0] contagem_duzias,
   output logic [3:0] duzias_unidades,
   output logic [3:0] duzias_dezenas,
   output logic       duzia_completa,
   output logic       embalando,
   output logic       linha_cheia
);

   localparam int TW = (TEMPO_EMBALAGEM > 1) ? $clog2(TEMPO_EMBALAGEM) : 1;
   localparam logic [TW-1:0] TIMER_FIM      = TW'(TEMPO_EMBALAGEM - 1);
   localparam logic [3:0]    GARRAFA_ULTIMA = 4'(GARRAFAS_POR_DUZIA - 1);
   localparam logic [6:0]    DUZIAS_MAX     = 7'(MAX_DUZIAS);

   typedef enum logic [1:0] {
      CONTANDO  = 2'd0,
      EMBALANDO = 2'd1,
      CHEIO     = 2'd2
   } estado_t;

   estado_t       estado;
   logic          garrafa_ant;
   logic [TW-1:0] timer;

   logic       evento;
   logic       aceita;
   logic       fecha_duzia;
   logic [6:0] duzias_prox;

   assign evento      = garrafa_aprovada & ~garrafa_ant;
   assign aceita      = evento & ~linha_cheia;
   assign fecha_duzia = aceita & (contagem_garrafas == GARRAFA_ULTIMA);
   assign duzias_prox = contagem_duzias + 7'd1;

   always_ff @(posedge clk) begin
      if (reset) begin
         // Starting high means a bottle already present during reset is not counted.
         garrafa_ant       <= 1'b1;
         estado            <= CONTANDO;
         timer             <= '0;
         contagem_garrafas <= '0;
         contagem_duzias   <= '0;
         duzias_unidades   <= '0;
         duzias_dezenas    <= '0;
         duzia_completa    <= 1'b0;
         embalando         <= 1'b0;
         linha_cheia       <= 1'b0;
      end else begin
         garrafa_ant    <= garrafa_aprovada;
         duzia_completa <= 1'b0;

         if (limpar_contagem) begin
            estado            <= CONTANDO;
            timer             <= '0;
            contagem_garrafas <= '0;
            contagem_duzias   <= '0;
            duzias_unidades   <= '0;
            duzias_dezenas    <= '0;
            embalando         <= 1'b0;
            linha_cheia       <= 1'b0;
         end else begin
            if (aceita) begin
               if (fecha_duzia) begin
                  contagem_garrafas <= '0;
                  contagem_duzias   <= duzias_prox;
                  duzias_dezenas    <= 4'(duzias_prox / 7'd10);
                  duzias_unidades   <= 4'(duzias_prox % 7'd10);
                  duzia_completa    <= 1'b1;
                  if (duzias_prox == DUZIAS_MAX)
                     linha_cheia <= 1'b1;
               end else begin
                  contagem_garrafas <= contagem_garrafas + 4'd1;
               end
            end

            case (estado)
               CONTANDO: begin
                  timer     <= '0;
                  embalando <= 1'b0;
                  if (fecha_duzia) begin
                     estado    <= EMBALANDO;
                     embalando <= 1'b1;
                  end
               end
               EMBALANDO: begin
                  // A new dozen during packaging restarts the on-time for the new box.
                  if (fecha_duzia) begin
                     timer     <= '0;
                     embalando <= 1'b1;
                  end else if (timer == TIMER_FIM) begin
                     timer     <= '0;
                     embalando <= 1'b0;
                     estado    <= linha_cheia ? CHEIO : CONTANDO;
                  end else begin
                     timer     <= timer + 1'b1;
                     embalando <= 1'b1;
                  end
               end
               CHEIO: begin
                  timer     <= '0;
                  embalando <= 1'b0;
               end
               default: begin
                  estado    <= CONTANDO;
                  timer     <= '0;
                  embalando <= 1'b0;
               end
            endcase
         end
      end
   end

endmodule

// File: doc/contador_duzias_embalagem.md
Name: contador_duzias_embalagem

Overview:
Downstream of the QC/discard stage. Counts approved bottles (rising edges of garrafa_aprovada), groups them into dozens, drives a timed packaging actuator for each completed dozen, and keeps the dozen total. When the line-capacity limit is reached, it raises linha_cheia to the master FSM and ignores further bottles until cleared.

Parameters:
GARRAFAS_POR_DUZIA, 12, bottles per box (2..15)
MAX_DUZIAS, 10, dozen total that marks the line full (1..99)
TEMPO_EMBALAGEM, 25000000, packaging actuator on-time in clk cycles (0.5 s at 50 MHz; benches override small)

Ports:
clk  in  1  50 MHz system clock
reset  in  1  synchronous, active-high global reset
garrafa_aprovada  in  1  level from QC stage, high while a bottle is approved; one count per rising edge
limpar_contagem  in  1  single-cycle pulse (debounced key) clearing all counts and the full condition
contagem_garrafas  out  4  bottles in the current, incomplete dozen (0..GARRAFAS_POR_DUZIA-1)
contagem_duzias  out  7  completed dozens, binary (0..MAX_DUZIAS)
duzias_unidades  out  4  BCD units of contagem_duzias, for 7-seg
duzias_dezenas  out  4  BCD tens of contagem_duzias, for 7-seg
duzia_completa  out  1  one-cycle pulse on each dozen completion
embalando  out  1  packaging actuator (LEDR), high for TEMPO_EMBALAGEM cycles per box
linha_cheia  out  1  high while contagem_duzias == MAX_DUZIAS; master stops the line

Behaviour:
- Reset (sync, on clk posedge): all outputs 0, state CONTANDO, timer 0. The edge-detect register garrafa_ant is set to 1, so an input held high through reset does not count.
- Edge detect: evento = garrafa_aprovada & ~garrafa_ant. garrafa_ant <= garrafa_aprovada every cycle.
- All outputs are registered. Counter update, duzia_completa, and BCD outputs are visible after the same edge that samples evento (1-clock latency).
- Bottle accept (evento and linha_cheia==0):
  - If contagem_garrafas < GARRAFAS_POR_DUZIA-1, increment it.
  - Otherwise: wrap contagem_garrafas to 0, increment contagem_duzias, pulse duzia_completa, load timer to 0, enter EMBALANDO.
- Bottle ignore: evento while linha_cheia==1 is discarded. No count, no pulse.
- State CONTANDO: embalando=0. Moves to EMBALANDO on dozen completion.
- State EMBALANDO:
  - embalando=1; timer increments each cycle.
  - When timer == TEMPO_EMBALAGEM-1: go to CHEIO if linha_cheia, else CONTANDO. embalando is high for exactly TEMPO_EMBALAGEM cycles.
  - Bottles arriving in EMBALANDO are counted into the next dozen.
  - Another dozen completion in EMBALANDO increments contagem_duzias, pulses duzia_completa, and restarts the timer from 0.
- State CHEIO: embalando=0, linha_cheia=1. Stays until limpar_contagem or reset.
- linha_cheia: asserts the cycle contagem_duzias becomes MAX_DUZIAS, even while still EMBALANDO; the final box finishes packaging.
- limpar_contagem:
  - In any state, same effect as reset except garrafa_ant, which keeps tracking normally.
  - Aborts packaging (embalando drops next cycle).
  - Takes priority over a simultaneous evento; that bottle is lost.
- BCD: dezenas = contagem_duzias / 10, unidades = contagem_duzias % 10. Updated in the same cycle as the binary count.
- contagem_duzias never exceeds MAX_DUZIAS. No wrap-around.
- Unreachable state encodings return to CONTANDO with the timer cleared.

Test Plan:
1. Reset with garrafa_aprovada=1 held, then release reset and keep the input high → no count. Drop low, then raise → contagem_garrafas=1 one cycle after the rise.
2. TEMPO_EMBALAGEM=4, 12 clean pulses → after the 12th: contagem_garrafas=0, contagem_duzias=1, duzia_completa high 1 cycle, embalando high exactly 4 cycles, state back to CONTANDO.
3. Input held high for 100 cycles per bottle (QC-stage style) → counts once per bottle, not per cycle. 5 bottles → contagem_garrafas=5.
4. MAX_DUZIAS=2, 25 bottles → linha_cheia=1 on the 24th bottle, embalando finishes 4 cycles, 25th ignored (contagem_garrafas=0, contagem_duzias=2). BCD outputs dezenas=0, unidades=2.
5. Bottles arriving during EMBALANDO → 3 bottles in the window give contagem_garrafas=3 after packaging. With GARRAFAS_POR_DUZIA=2 and a long TEMPO, a second dozen completed mid-packaging restarts the timer.
6. limpar_contagem in EMBALANDO coincident with a bottle edge → next cycle all counts 0, embalando=0, linha_cheia=0, that bottle not counted. A count of 11 dozens (MAX_DUZIAS=99) gives dezenas=1, unidades=1.
